// File: rtl/uart_echo_buffer_if.sv
// uart_echo_buffer_if: signals between a uart core (RX/TX sides) and the echo
// controller, plus the controller's status outputs.
//   master : uart core / environment side (drives RX word and TX idle status)
//   slave  : echo controller side (drives unload/load strobes and status)
interface uart_echo_buffer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
);
    logic              rx_empty;
    logic [DATA_W-1:0] rx_data;
    logic              uld_rx_data;
    logic              tx_empty;
    logic              ld_tx_data;
    logic [DATA_W-1:0] tx_data;
    logic [DATA_W-1:0] last_byte;
    logic [ADDR_W:0]   fifo_count;
    logic              overflow;
    logic [CNT_W-1:0]  overflow_cnt;

    modport master (
        output rx_empty, rx_data, tx_empty,
        input  uld_rx_data, ld_tx_data, tx_data, last_byte,
               fifo_count, overflow, overflow_cnt
    );

    modport slave (
        input  rx_empty, rx_data, tx_empty,
        output uld_rx_data, ld_tx_data, tx_data, last_byte,
               fifo_count, overflow, overflow_cnt
    );
endinterface

// File: rtl/uart_echo_buffer.sv
// uart_echo_buffer: unloads words from the uart receiver, optionally transforms
// them, queues them in a DEPTH-entry circular FIFO and hands them back to the
// uart transmitter in arrival order. Overflow is either counted and dropped or
// held back in the uart, depending on DROP_ON_FULL.
module uart_echo_buffer #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int MODE         = 0,
    parameter int DROP_ON_FULL = 1,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    uart_echo_buffer_if.slave bus
);
    typedef enum logic {R_IDLE, R_CAP}  rx_state_t;
    typedef enum logic {T_IDLE, T_LOAD} tx_state_t;

    localparam logic [DATA_W-1:0] LC_FIRST = DATA_W'(8'h61);   // 'a'
    localparam logic [DATA_W-1:0] LC_LAST  = DATA_W'(8'h7A);   // 'z'
    localparam logic [DATA_W-1:0] CASE_BIT = DATA_W'(8'h20);
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);

    rx_state_t         r_rx_state, w_rx_next;
    tx_state_t         r_tx_state, w_tx_next;
    logic              r_uld, w_uld_next;
    logic              r_drop, w_drop_next;
    logic              w_push, w_drop_evt, w_pop, w_load;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              w_full, w_empty;
    logic [DATA_W-1:0] w_push_data;
    logic [DATA_W-1:0] r_tx_data, r_last;
    logic              r_ld;
    logic              r_overflow;
    logic [CNT_W-1:0]  r_ovf_cnt;

    // Word transform applied on the way into the FIFO.
    function automatic logic [DATA_W-1:0] f_xform(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] y;
        y = d;
        if (MODE == 1)
            y = ~d;
        else if (MODE == 2 && d >= LC_FIRST && d <= LC_LAST)
            y = d - CASE_BIT;
        return y;
    endfunction

    assign w_push_data = f_xform(bus.rx_data);
    assign w_full      = (r_count == FULL_CNT);
    assign w_empty     = (r_count == '0);

    // RX state register with the registered unload strobe and drop flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_state <= R_IDLE;
            r_uld      <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_rx_state <= w_rx_next;
            r_uld      <= w_uld_next;
            r_drop     <= w_drop_next;
        end
    end

    // RX next state: unload a waiting word, decide store or drop, then capture it.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path infers a latch; combinational blocks use '=', clocked blocks '<='.
        w_rx_next   = r_rx_state;
        w_uld_next  = 1'b0;
        w_drop_next = r_drop;
        w_push      = 1'b0;
        w_drop_evt  = 1'b0;
        case (r_rx_state)
            R_IDLE: begin
                if (!bus.rx_empty) begin
                    if (!w_full) begin
                        w_rx_next   = R_CAP;
                        w_uld_next  = 1'b1;
                        w_drop_next = 1'b0;
                    end else if (DROP_ON_FULL != 0) begin
                        w_rx_next   = R_CAP;
                        w_uld_next  = 1'b1;
                        w_drop_next = 1'b1;
                    end
                end
            end
            R_CAP: begin
                w_rx_next = R_IDLE;
                if (r_drop)
                    w_drop_evt = 1'b1;
                else
                    w_push = 1'b1;
            end
            default: w_rx_next = R_IDLE;
        endcase
    end

    // TX state register, load request, outgoing word and last-sent display.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_state <= T_IDLE;
            r_ld       <= 1'b0;
            r_tx_data  <= '0;
            r_last     <= '0;
        end else begin
            r_tx_state <= w_tx_next;
            if (w_load) begin
                r_ld      <= 1'b1;
                r_tx_data <= r_mem[r_rd_ptr];
            end else if (w_pop) begin
                r_ld   <= 1'b0;
                r_last <= r_tx_data;
            end
        end
    end

    // TX next state: load the head when the transmitter is idle, pop once it starts.
    always_comb begin
        w_tx_next = r_tx_state;
        w_load    = 1'b0;
        w_pop     = 1'b0;
        case (r_tx_state)
            T_IDLE: begin
                if (!w_empty && bus.tx_empty) begin
                    w_tx_next = T_LOAD;
                    w_load    = 1'b1;
                end
            end
            T_LOAD: begin
                if (!bus.tx_empty) begin
                    w_tx_next = T_IDLE;
                    w_pop     = 1'b1;
                end
            end
            default: w_tx_next = T_IDLE;
        endcase
    end

    // FIFO storage write port.
    // NOTE: the storage array is deliberately not reset; pointers and count alone define emptiness.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_push_data;
    end

    // FIFO pointers (wrap naturally at DEPTH) and registered occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow flag and saturating dropped-word counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
            r_ovf_cnt  <= '0;
        end else if (w_drop_evt) begin
            r_overflow <= 1'b1;
            if (r_ovf_cnt != '1)
                r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
        end
    end

    assign bus.uld_rx_data  = r_uld;
    assign bus.ld_tx_data   = r_ld;
    assign bus.tx_data      = r_tx_data;
    assign bus.last_byte    = r_last;
    assign bus.fifo_count   = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.overflow_cnt = r_ovf_cnt;
endmodule

// File: tb/tb_uart_echo_buffer.sv
// tb_uart_echo_buffer: three echo buffers (pass-through/drop, invert/backpressure,
// upper-case/drop) each driven by a small uart model. A queue-based reference
// tracks expected words, occupancy and drop status; the monitor compares every
// word handed to TX and the status outputs every cycle.
module tb_uart_echo_buffer;
    localparam int N     = 3;
    localparam int DEPTH = 16;
    localparam int MODE_A [N] = '{0, 1, 2};
    localparam int DROP_A [N] = '{1, 0, 1};

    typedef logic [7:0] byte_t;

    logic clk;
    logic rst_n;

    logic  drv_rx_empty [N];
    byte_t drv_rx_data  [N];
    logic  drv_tx_empty [N];
    logic  obs_uld [N], obs_ld [N], obs_ovf [N];
    byte_t obs_tx  [N], obs_last [N], obs_ocnt [N];
    logic [4:0] obs_cnt [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        uart_echo_buffer_if #(.DATA_W(8), .ADDR_W(4), .CNT_W(8)) bus ();
        assign bus.rx_empty = drv_rx_empty[g];
        assign bus.rx_data  = drv_rx_data[g];
        assign bus.tx_empty = drv_tx_empty[g];
        assign obs_uld[g]   = bus.uld_rx_data;
        assign obs_ld[g]    = bus.ld_tx_data;
        assign obs_tx[g]    = bus.tx_data;
        assign obs_last[g]  = bus.last_byte;
        assign obs_cnt[g]   = bus.fifo_count;
        assign obs_ovf[g]   = bus.overflow;
        assign obs_ocnt[g]  = bus.overflow_cnt;

        uart_echo_buffer #(
            .DATA_W(8), .DEPTH(DEPTH), .ADDR_W(4),
            .MODE(MODE_A[g]), .DROP_ON_FULL(DROP_A[g]), .CNT_W(8)
        ) dut (
            .clk    (clk),
            .reset_n(rst_n),
            .bus    (bus)
        );
    end

    // Reference state per instance.
    byte_t rx_q  [N][$];   // words waiting in the uart receiver
    byte_t exp_q [N][$];   // words accepted into the FIFO, in order
    int    m_cnt [N], prev_cnt [N], m_ocnt [N], busy [N];
    logic  m_ovf [N];
    byte_t m_last [N], pop_val [N];
    bit    cap_pend [N], cap_drop [N], pop_pend [N], rx_pop_pend [N];
    bit    hold [N], stall [N];
    int    present_cyc [N], ld_rise_cyc [N];
    logic  prev_ld [N], prev_rx_empty [N];
    int    cyc;
    bit    started;

    int n_cmp;
    int n_bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h at %0t", name, idx, act, exp, $time);
        end
    endtask

    function automatic byte_t xform(input int mode, input byte_t b);
        case (mode)
            1:       return ~b;
            2:       return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
            default: return b;
        endcase
    endfunction

    task automatic clear_model(input int i);
        rx_q[i].delete();
        exp_q[i].delete();
        m_cnt[i] = 0; prev_cnt[i] = 0; m_ocnt[i] = 0; busy[i] = 0;
        m_ovf[i] = 1'b0; m_last[i] = 8'h00; pop_val[i] = 8'h00;
        cap_pend[i] = 0; cap_drop[i] = 0; pop_pend[i] = 0; rx_pop_pend[i] = 0;
        prev_ld[i] = 1'b0; prev_rx_empty[i] = 1'b1;
        drv_rx_empty[i] = 1'b1;
        drv_tx_empty[i] = 1'b1;
    endtask

    // One falling-edge step of the uart model and reference for instance i.
    task automatic step(input int i);
        byte_t w;
        // effects of the rising edge just past
        if (rx_pop_pend[i]) begin
            w = rx_q[i].pop_front();
            rx_pop_pend[i] = 0;
        end
        if (cap_pend[i]) begin
            if (cap_drop[i]) begin
                m_ovf[i] = 1'b1;
                if (m_ocnt[i] < 255) m_ocnt[i]++;
            end else begin
                m_cnt[i]++;
            end
            cap_pend[i] = 0;
        end
        if (pop_pend[i]) begin
            m_cnt[i]--;
            m_last[i] = pop_val[i];
            pop_pend[i] = 0;
        end
        // status outputs
        check("fifo_count",   i, obs_cnt[i],  m_cnt[i]);
        check("overflow",     i, obs_ovf[i],  m_ovf[i]);
        check("overflow_cnt", i, obs_ocnt[i], m_ocnt[i]);
        check("last_byte",    i, obs_last[i], m_last[i]);
        // receive side
        if (prev_cnt[i] == DEPTH && DROP_A[i] == 0)
            check("uld_held_when_full", i, obs_uld[i], 0);
        if (obs_uld[i]) begin
            check("uld_needs_word", i, drv_rx_empty[i], 0);
            cap_drop[i] = (prev_cnt[i] == DEPTH);
            if (!cap_drop[i])
                exp_q[i].push_back(xform(MODE_A[i], drv_rx_data[i]));
            cap_pend[i]    = 1;
            rx_pop_pend[i] = 1;
        end
        // transmit side
        if (obs_ld[i] && !prev_ld[i]) ld_rise_cyc[i] = cyc;
        prev_ld[i] = obs_ld[i];
        if (obs_ld[i] && drv_tx_empty[i] && !stall[i]) begin
            check("tx_word_expected", i, exp_q[i].size() > 0, 1);
            if (exp_q[i].size() > 0) begin
                pop_val[i] = exp_q[i].pop_front();
                check("tx_data", i, obs_tx[i], pop_val[i]);
                pop_pend[i] = 1;
            end
            busy[i] = $urandom_range(1, 3);
            drv_tx_empty[i] = 1'b0;
        end else begin
            if (busy[i] > 0) busy[i]--;
            drv_tx_empty[i] = stall[i] || (busy[i] == 0 && !hold[i]);
        end
        prev_cnt[i] = m_cnt[i];
        // present the next received word
        drv_rx_empty[i] = (rx_q[i].size() == 0);
        if (rx_q[i].size() > 0) drv_rx_data[i] = rx_q[i][0];
        if (prev_rx_empty[i] && !drv_rx_empty[i]) present_cyc[i] = cyc;
        prev_rx_empty[i] = drv_rx_empty[i];
    endtask

    // Monitor and uart model, all instances, on every falling edge.
    initial begin
        cyc = 0;
        for (int i = 0; i < N; i++) begin
            drv_rx_data[i] = 8'h00;
            present_cyc[i] = 0;
            ld_rise_cyc[i] = 0;
            clear_model(i);
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < N; i++) begin
                if (!rst_n || !started) clear_model(i);
                else step(i);
            end
        end
    end

    task automatic check_reset_outputs();
        for (int i = 0; i < N; i++) begin
            check("rst_uld",          i, obs_uld[i],  0);
            check("rst_ld_tx_data",   i, obs_ld[i],   0);
            check("rst_tx_data",      i, obs_tx[i],   0);
            check("rst_last_byte",    i, obs_last[i], 0);
            check("rst_fifo_count",   i, obs_cnt[i],  0);
            check("rst_overflow",     i, obs_ovf[i],  0);
            check("rst_overflow_cnt", i, obs_ocnt[i], 0);
        end
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            #1;
            done = 1;
            for (int i = 0; i < N; i++)
                if (rx_q[i].size() != 0 || exp_q[i].size() != 0 || m_cnt[i] != 0 ||
                    obs_ld[i] || pop_pend[i] || cap_pend[i])
                    done = 0;
        end
        check("drain_done", 0, done, 1);
    endtask

    initial begin
        byte_t w;
        n_cmp = 0;
        n_bad = 0;
        started = 0;
        for (int i = 0; i < N; i++) begin
            hold[i] = 0;
            stall[i] = 0;
        end
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        started = 1;

        // Single words per mode, plus first-word latency on the pass-through instance.
        @(negedge clk);
        rx_q[0].push_back(8'h41);
        rx_q[1].push_back(8'h0F);
        rx_q[2].push_back(8'h61);
        rx_q[2].push_back(8'h5A);
        rx_q[2].push_back(8'h7B);
        wait_idle(200);
        check("rx_to_ld_latency", 0, ld_rise_cyc[0] - present_cyc[0], 3);
        check("last_byte_single", 0, obs_last[0], 8'h41);
        check("last_byte_invert", 1, obs_last[1], 8'hF0);
        check("last_byte_upper",  2, obs_last[2], 8'h7B);

        // Fill to DEPTH with the transmitter busy, then one word too many.
        for (int i = 0; i < N; i++) hold[i] = 1;
        repeat (2) @(negedge clk);
        for (int v = 0; v <= DEPTH; v++)
            for (int i = 0; i < N; i++) rx_q[i].push_back(8'(v));
        repeat (60) @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            check("full_count",        i, obs_cnt[i],  DEPTH);
            check("full_overflow",     i, obs_ovf[i],  DROP_A[i]);
            check("full_overflow_cnt", i, obs_ocnt[i], DROP_A[i]);
        end
        check("backpressure_word_waiting", 1, drv_rx_empty[1], 0);
        for (int i = 0; i < N; i++) hold[i] = 0;
        wait_idle(400);

        // Random traffic with bursts of transmitter stalls; exercises wrap and push/pop overlap.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (c % 25 == 0)
                for (int i = 0; i < N; i++) hold[i] = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < N; i++)
                if (rx_q[i].size() < 3 && $urandom_range(0, 1) == 1) begin
                    if ($urandom_range(0, 1) == 1) w = 8'($urandom_range(8'h60, 8'h7B));
                    else w = 8'($urandom_range(0, 255));
                    rx_q[i].push_back(w);
                end
        end
        for (int i = 0; i < N; i++) hold[i] = 0;
        wait_idle(800);

        // Reset while a load request is pending with five words queued.
        for (int i = 0; i < N; i++) hold[i] = 1;
        @(negedge clk);
        for (int v = 0; v < 5; v++)
            for (int i = 0; i < N; i++) rx_q[i].push_back(8'(8'h30 + v));
        repeat (20) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            stall[i] = 1;
            hold[i] = 0;
        end
        repeat (4) @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            check("pre_reset_ld",    i, obs_ld[i],  1);
            check("pre_reset_count", i, obs_cnt[i], 5);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) stall[i] = 0;
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) rx_q[i].push_back(8'h61);
        wait_idle(100);
        check("post_reset_echo", 0, obs_last[0], 8'h61);
        check("post_reset_echo", 1, obs_last[1], 8'h9E);
        check("post_reset_echo", 2, obs_last[2], 8'h41);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
